// File: rtl/imm_encoder.sv
// Immediate encoder and `li` expander: turns base word + immediate into RV32I words.
// Optional range checking is enabled by defining IMMENC_RANGE_CHECK_EN.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_li,
  input  logic [2:0]  req_immsrc,
  input  logic [31:0] req_base,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t      state_q, state_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;
  logic [31:0] addi_q, addi_d;

  logic        accept;
  logic        out_hs;
  logic [31:0] enc_word;
  logic        enc_fmt_ok;
  logic        enc_range_ok;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [4:0]  li_rd;
  logic [31:0] li_first;
  logic [31:0] li_second;
  logic        li_two;

  assign out_valid = (state_q != IDLE);
  assign out_hs    = out_valid & out_ready;
  assign req_ready = rst_n & ((state_q == IDLE) | (out_hs & out_last_q));
  assign accept    = req_valid & req_ready;
  assign out_inst  = out_inst_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

  always_comb begin
    enc_word   = req_base;
    enc_fmt_ok = 1'b1;
    case (req_immsrc)
      3'b000: enc_word = req_base | {req_imm[11:0], 20'd0};
      3'b001: enc_word = req_base | {req_imm[11:5], 13'd0, req_imm[4:0], 7'd0};
      3'b101: enc_word = req_base | {req_imm[12], req_imm[10:5], 13'd0,
                                     req_imm[4:1], req_imm[11], 7'd0};
      3'b010: enc_word = req_base | {req_imm[31:12], 12'd0};
      3'b011: enc_word = req_base | {req_imm[20], req_imm[10:1], req_imm[11],
                                     req_imm[19:12], 12'd0};
      default: enc_fmt_ok = 1'b0;
    endcase
  end

`ifdef IMMENC_RANGE_CHECK_EN
  // Representable means the bits above the field are a pure sign extension.
  always_comb begin
    enc_range_ok = 1'b1;
    case (req_immsrc)
      3'b000, 3'b001: enc_range_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
      3'b101: enc_range_ok = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
      3'b011: enc_range_ok = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];
      3'b010: enc_range_ok = ~(|req_imm[11:0]);
      default: enc_range_ok = 1'b1;
    endcase
  end
`else
  assign enc_range_ok = 1'b1;
`endif

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending lo.
  always_comb begin
    li_lo     = req_imm[11:0];
    li_hi     = req_imm[31:12] + {19'd0, req_imm[11]};
    li_rd     = req_base[11:7];
    li_two    = 1'b0;
    li_second = {li_lo, li_rd, 3'b000, li_rd, 7'h13};
    if (li_hi == 20'd0) begin
      li_first = {li_lo, 5'd0, 3'b000, li_rd, 7'h13};
    end else begin
      li_first = {li_hi, li_rd, 7'h37};
      li_two   = (li_lo != 12'd0);
    end
  end

  always_comb begin
    state_d    = state_q;
    out_inst_d = out_inst_q;
    out_last_d = out_last_q;
    out_err_d  = out_err_q;
    addi_d     = addi_q;
    if (accept) begin
      state_d = EMIT1;
      if (req_li) begin
        out_inst_d = li_first;
        out_last_d = ~li_two;
        out_err_d  = 1'b0;
        addi_d     = li_second;
      end else begin
        out_inst_d = enc_word;
        out_last_d = 1'b1;
        out_err_d  = ~enc_fmt_ok | ~enc_range_ok;
      end
    end else if (out_hs) begin
      if ((state_q == EMIT1) && !out_last_q) begin
        state_d    = EMIT2;
        out_inst_d = addi_q;
        out_last_d = 1'b1;
        out_err_d  = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_inst_q <= 32'd0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
      addi_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      out_inst_q <= out_inst_d;
      out_last_q <= out_last_d;
      out_err_q  <= out_err_d;
      addi_q     <= addi_d;
    end
  end

endmodule
